iic_slave_wr: RTL and testbench



---
 rtl/iic_slave_wr.sv | 184 ++++++++++++++++++
 tb/tb_iic_slave_wr.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_wr.sv
// ============================================================================
// Module   : iic_slave_wr
// Purpose  : IIC register-write responder (START, chip, reg, data, STOP);
//            ACKs accepted bytes and emits one-cycle register write strobes.
// Options  : IIC_SLV_AUTOINC_EN - multi-byte writes with address auto-increment
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iic_slave_wr #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHIP      = 3'd1,
    S_ACK_CHIP  = 3'd2,
    S_REG       = 3'd3,
    S_ACK_REG   = 3'd4,
    S_DATA      = 3'd5,
    S_ACK_DATA  = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       busy_q, busy_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;
  logic byte_done;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign sda_rise  = sda_s & ~sda_hist_q;
  assign sda_fall  = ~sda_s & sda_hist_q;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  // Synchronisers reset to the idle-bus level so no phantom edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      addr_q    <= 8'h00;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;

    if (start_det) begin
      state_d   = S_CHIP;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_CHIP, S_REG, S_DATA: begin
          if (scl_rise && (bit_cnt_q != 4'd8)) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            if (state_q == S_CHIP) begin
              if ((shift_q[7:1] == DEV_ADDR) && !shift_q[0]) begin
                state_d  = S_ACK_CHIP;
                sda_oe_d = 1'b1;
              end else begin
                state_d  = S_WAIT_STOP;
              end
            end else if (state_q == S_REG) begin
              addr_d   = shift_q;
              state_d  = S_ACK_REG;
              sda_oe_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = shift_q;
              sda_oe_d  = 1'b1;
              state_d   = S_ACK_DATA;
`ifdef IIC_SLV_AUTOINC_EN
              addr_d    = addr_q + 8'd1;
`endif
            end
          end
        end
        S_ACK_CHIP, S_ACK_REG, S_ACK_DATA: begin
          // The next falling SCL edge ends the 9th (ACK) clock.
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if (state_q == S_ACK_CHIP) begin
              state_d = S_REG;
            end else if (state_q == S_ACK_REG) begin
              state_d = S_DATA;
            end else begin
`ifdef IIC_SLV_AUTOINC_EN
              state_d = S_DATA;
`else
              state_d = S_WAIT_STOP;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_iic_slave_wr.sv
// ============================================================================
// Module   : tb_iic_slave_wr
// Purpose  : Bus-master stimulus with a transaction-level model for iic_slave_wr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iic_slave_wr;

  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       bus_sda;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data;

  assign bus_sda = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  iic_slave_wr #(.DEV_ADDR(DEV)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (m_scl),
    .sda_i   (bus_sda),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe = 0;

  // Transaction-level model: 0 idle, 1 expect chip, 2 expect reg, 3 data, 4 ignored
  int          m_phase = 0;
  logic        m_busy  = 1'b0;
  logic [7:0]  m_addr  = 8'h00;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output logic ack);
    ack = 1'b0;
    case (m_phase)
      1: begin
        if (b == {DEV, 1'b0}) begin ack = 1'b1; m_phase = 2; end
        else m_phase = 4;
      end
      2: begin ack = 1'b1; m_addr = b; m_phase = 3; end
      3: begin
        ack = 1'b1;
        exp_q.push_back({m_addr, b});
`ifdef IIC_SLV_AUTOINC_EN
        m_addr = m_addr + 8'd1;
`else
        m_phase = 4;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start;
    m_sda = 1'b1; wclk(6);
    m_scl = 1'b1; wclk(8);
    m_sda = 1'b0;
    m_phase = 1; m_busy = 1'b1;
    wclk(8);
    m_scl = 1'b0; wclk(2);
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_sda = b; wclk(6);
    m_scl = 1'b1; wclk(4);
    s = bus_sda;
    chk("busy", busy, m_busy);
    wclk(4);
    m_scl = 1'b0; wclk(2);
  endtask

  task automatic m_bits(input logic [7:0] b, input int n);
    logic s;
    for (int i = 7; i > 7 - n; i--) begin
      m_bit(b[i], s);
      chk("data_bit_on_bus", s, b[i]);
    end
  endtask

  task automatic m_byte(input logic [7:0] b, output logic acked);
    logic s, ack;
    m_bits(b, 8);
    model_byte(b, ack);
    m_bit(1'b1, s);
    acked = ~s;
    chk("ack_vs_model", acked, ack);
  endtask

  task automatic m_stop;
    m_sda = 1'b0; wclk(6);
    m_scl = 1'b1; wclk(8);
    m_sda = 1'b1;
    m_phase = 0; m_busy = 1'b0;
    wclk(8);
    chk("busy_after_stop", busy, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sda_oe"}, sda_oe, 1'b0);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_wr_addr"}, wr_addr, 8'h00);
    chk({tag, "_wr_data"}, wr_data, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Every strobe must match the model's next expected write and coincide
  // with the first cycle of the data ACK drive.
  logic prev_oe = 1'b0;
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        n_strobe++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_strobe: got addr %0h data %0h expected none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_addr", wr_addr, e[15:8]);
          chk("strobe_data", wr_data, e[7:0]);
        end
        chk("strobe_oe_edge", {prev_oe, sda_oe}, 2'b01);
      end
      prev_oe = sda_oe;
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    int   n0;
    logic [7:0] b;

    wclk(4);
    chk_reset_vals("reset");
    rst = 1'b0;
    wclk(10);

    // Basic write
    n0 = n_strobe;
    m_start;
    m_byte(8'hA0, a); chk("t1_ack_chip", a, 1'b1);
    m_byte(8'h12, a); chk("t1_ack_reg", a, 1'b1);
    m_byte(8'hA5, a); chk("t1_ack_data", a, 1'b1);
    m_stop;
    chk("t1_strobes", n_strobe - n0, 1);
    chk("t1_wr_addr", wr_addr, 8'h12);
    chk("t1_wr_data", wr_data, 8'hA5);

    // Wrong device address
    n0 = n_strobe;
    m_start;
    m_byte(8'hA2, a); chk("t2_nack_chip", a, 1'b0);
    m_byte(8'h12, a); chk("t2_nack_reg", a, 1'b0);
    m_byte(8'h34, a); chk("t2_nack_data", a, 1'b0);
    m_stop;
    chk("t2_strobes", n_strobe - n0, 0);

    // Read request
    n0 = n_strobe;
    m_start;
    m_byte(8'hA1, a); chk("t3_nack_read", a, 1'b0);
    m_byte(8'h55, a); chk("t3_nack_next", a, 1'b0);
    m_stop;
    chk("t3_strobes", n_strobe - n0, 0);

    // Two data bytes at register 0xFF
    n0 = n_strobe;
    m_start;
    m_byte(8'hA0, a);
    m_byte(8'hFF, a);
    m_byte(8'h11, a); chk("t4_ack_first", a, 1'b1);
    m_byte(8'h22, a);
`ifdef IIC_SLV_AUTOINC_EN
    chk("t4_ack_second", a, 1'b1);
`else
    chk("t4_ack_second", a, 1'b0);
`endif
    m_stop;
`ifdef IIC_SLV_AUTOINC_EN
    chk("t4_strobes", n_strobe - n0, 2);
    chk("t4_wr_addr", wr_addr, 8'h00);
    chk("t4_wr_data", wr_data, 8'h22);
`else
    chk("t4_strobes", n_strobe - n0, 1);
    chk("t4_wr_addr", wr_addr, 8'hFF);
    chk("t4_wr_data", wr_data, 8'h11);
`endif

    // Repeated START inside a data byte
    n0 = n_strobe;
    m_start;
    m_byte(8'hA0, a);
    m_byte(8'h40, a);
    m_bits(8'hB0, 4);
    m_start;
    m_byte(8'hA0, a); chk("t5_ack_chip", a, 1'b1);
    m_byte(8'h03, a);
    m_byte(8'h7E, a);
    m_stop;
    chk("t5_strobes", n_strobe - n0, 1);
    chk("t5_wr_addr", wr_addr, 8'h03);
    chk("t5_wr_data", wr_data, 8'h7E);

    // Reset in the middle of the register byte
    n0 = n_strobe;
    m_start;
    m_byte(8'hA0, a);
    m_bits(8'h9C, 4);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("t6");
    m_phase = 0; m_busy = 1'b0;
    @(negedge clk); rst = 1'b0;
    begin
      logic [7:0] rb;
      logic s;
      rb = 8'h9C;
      for (int i = 3; i >= 0; i--) begin
        m_bit(rb[i], s);
        chk("t6_bit_on_bus", s, rb[i]);
      end
      m_bit(1'b1, s);
      chk("t6_nack_after_reset", s, 1'b1);
    end
    m_byte(8'h55, a); chk("t6_nack_data", a, 1'b0);
    m_stop;
    chk("t6_strobes", n_strobe - n0, 0);

    // Randomised transactions
    for (int t = 0; t < 20; t++) begin
      int nd;
      m_start;
      if ($urandom_range(0, 3) == 0) begin
        m_byte(8'hA0, a);
        m_byte(8'($urandom), a);
        m_bits(8'($urandom), $urandom_range(1, 7));
        m_start;
      end
      b = ($urandom_range(0, 3) != 0) ? 8'hA0 : 8'($urandom);
      m_byte(b, a);
      m_byte(8'($urandom), a);
      nd = $urandom_range(1, 3);
      for (int k = 0; k < nd; k++) m_byte(8'($urandom), a);
      m_stop;
      wclk($urandom_range(2, 20));
    end

    wclk(10);
    chk("pending_strobes", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
